// File: rtl/cmul_stream.sv
// cmul_stream: streaming complex multiplier c = a * b (or a * conj(b)).
//
// Four-stage pipeline (operand register, products, sums, rescale/output),
// all stages advanced by a single enable so backpressure stalls the whole
// pipe. The result is rescaled with round-half-up and an arithmetic right
// shift by FRAC_SHIFT, then reduced to OUT_WIDTH.
//
// Optional feature (macro CMUL_SATURATE_EN):
//   defined   - out-of-range components clamp to the nearer limit, out_ovf flags it
//   undefined - components wrap to their low OUT_WIDTH bits, out_ovf stays 0
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline advance)
//   in_conj             1: multiply by conj(b) for this sample
//   in_tag              sideband returned unchanged on out_tag
//   a_re, a_im          signed sample operand (DATA_WIDTH)
//   b_re, b_im          signed coefficient operand (COEF_WIDTH)
//   out_valid/out_ready output handshake
//   c_re, c_im          signed scaled result (OUT_WIDTH)
//   out_tag             tag of the current result
//   out_ovf             result was saturated
module cmul_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_conj,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [COEF_WIDTH-1:0] b_re,
  input  logic [COEF_WIDTH-1:0] b_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  c_re,
  output logic [OUT_WIDTH-1:0]  c_im,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_ovf
);

  // Full-precision product width, and a working width for sums that is at
  // least P+2 bits and always wide enough to hold the OUT_WIDTH limits.
  localparam int P  = DATA_WIDTH + COEF_WIDTH;
  localparam int SW = (P + 2 > OUT_WIDTH + 1) ? P + 2 : OUT_WIDTH + 1;

  localparam logic signed [SW-1:0] ONE  = SW'(1);
  localparam logic signed [SW-1:0] HALF = ONE <<< (FRAC_SHIFT - 1);
`ifdef CMUL_SATURATE_EN
  localparam logic signed [SW-1:0] OUT_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;
`endif

  // Round half up (toward +inf) then arithmetic shift.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = x + HALF;
    return t >>> FRAC_SHIFT;
  endfunction

  // Reduce to OUT_WIDTH. Returns {overflow_flag, value}.
  function automatic logic [OUT_WIDTH:0] fit_out(input logic signed [SW-1:0] x);
`ifdef CMUL_SATURATE_EN
    if (x > OUT_MAX)      return {1'b1, OUT_WIDTH'(OUT_MAX)};
    else if (x < OUT_MIN) return {1'b1, OUT_WIDTH'(OUT_MIN)};
    else                  return {1'b0, OUT_WIDTH'(x)};
`else
    return {1'b0, OUT_WIDTH'(x)};
`endif
  endfunction

  logic adv;
  logic vld_p1, vld_p2, vld_p3;

  logic signed [DATA_WIDTH-1:0] ar_p1, ai_p1;
  logic signed [COEF_WIDTH-1:0] br_p1, bi_p1;
  logic                         conj_p1;
  logic [TAG_WIDTH-1:0]         tag_p1;

  logic signed [P-1:0]          pr1_p2, pr2_p2, pr3_p2, pr4_p2;
  logic                         conj_p2;
  logic [TAG_WIDTH-1:0]         tag_p2;

  logic signed [SW-1:0]         re_p3, im_p3;
  logic [TAG_WIDTH-1:0]         tag_p3;

  logic signed [SW-1:0]         re_sh, im_sh;
  logic [OUT_WIDTH:0]           re_fit, im_fit;

  // One enable for the whole pipe: an empty output slot or a consuming sink.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Control path: valid bits and the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
      c_re      <= '0;
      c_im      <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
      // ---- S3 -> S4: rescale and reduce ----
      // Bubbles leave the last result in place rather than loading stale data.
      if (vld_p3) begin
        c_re    <= re_fit[OUT_WIDTH-1:0];
        c_im    <= im_fit[OUT_WIDTH-1:0];
        out_tag <= tag_p3;
        out_ovf <= re_fit[OUT_WIDTH] | im_fit[OUT_WIDTH];
      end
    end
  end

  // Datapath: not reset; loads only when a valid sample moves into the stage.
  always_ff @(posedge clock) begin
    // ---- input -> S1: operand register ----
    if (adv && in_valid) begin
      ar_p1   <= a_re;
      ai_p1   <= a_im;
      br_p1   <= b_re;
      bi_p1   <= b_im;
      conj_p1 <= in_conj;
      tag_p1  <= in_tag;
    end
    // ---- S1 -> S2: four full-precision products ----
    if (adv && vld_p1) begin
      pr1_p2  <= P'(ar_p1) * P'(br_p1);
      pr2_p2  <= P'(ai_p1) * P'(bi_p1);
      pr3_p2  <= P'(ar_p1) * P'(bi_p1);
      pr4_p2  <= P'(ai_p1) * P'(br_p1);
      conj_p2 <= conj_p1;
      tag_p2  <= tag_p1;
    end
    // ---- S2 -> S3: sums, sign-extended so no overflow is possible ----
    if (adv && vld_p2) begin
      if (conj_p2) begin
        re_p3 <= SW'(pr1_p2) + SW'(pr2_p2);
        im_p3 <= SW'(pr4_p2) - SW'(pr3_p2);
      end else begin
        re_p3 <= SW'(pr1_p2) - SW'(pr2_p2);
        im_p3 <= SW'(pr4_p2) + SW'(pr3_p2);
      end
      tag_p3 <= tag_p2;
    end
  end

  assign re_sh  = round_shift(re_p3);
  assign im_sh  = round_shift(im_p3);
  assign re_fit = fit_out(re_sh);
  assign im_fit = fit_out(im_sh);

endmodule

// File: tb/tb_cmul_stream.sv
// Testbench for cmul_stream: directed cases, randomized streams with
// backpressure, and an asynchronous reset in the middle of a stream.
`timescale 1ns/1ps
module tb_cmul_stream;
  localparam int DW = 16, CW = 16, OW = 16, FS = 15, TW = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_conj;
  logic [TW-1:0]  in_tag;
  logic [DW-1:0]  a_re, a_im;
  logic [CW-1:0]  b_re, b_im;
  logic           out_valid, out_ready;
  logic [OW-1:0]  c_re, c_im;
  logic [TW-1:0]  out_tag;
  logic           out_ovf;

  int checks = 0;
  int failures = 0;

  cmul_stream #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .TAG_WIDTH(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj), .in_tag(in_tag),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_re(c_re), .c_im(c_im), .out_tag(out_tag), .out_ovf(out_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: exact complex product in 64-bit integers, rescaled by
  // floor(x/2^FS + 1/2), then clamped or wrapped. Returns {ovf, re, im}.
  function automatic logic [32:0] ref_cmul(input logic signed [15:0] ar, ai, br, bi,
                                           input logic cj);
    longint re, im;
    logic   ovf;
    if (cj) begin
      re = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
      im = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
    end else begin
      re = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
      im = longint'(ai) * longint'(br) + longint'(ar) * longint'(bi);
    end
    re = (re + (longint'(1) <<< (FS - 1))) >>> FS;
    im = (im + (longint'(1) <<< (FS - 1))) >>> FS;
    ovf = 1'b0;
`ifdef CMUL_SATURATE_EN
    begin
      longint hi, lo;
      hi = (longint'(1) <<< (OW - 1)) - 1;
      lo = -hi - 1;
      if (re > hi) begin re = hi; ovf = 1'b1; end
      else if (re < lo) begin re = lo; ovf = 1'b1; end
      if (im > hi) begin im = hi; ovf = 1'b1; end
      else if (im < lo) begin im = lo; ovf = 1'b1; end
    end
`endif
    return {ovf, re[15:0], im[15:0]};
  endfunction

  // Single sample through an idle pipe with out_ready=1; checks exact latency.
  // Entered and left at posedge+1.
  task automatic one(input string name, input logic [15:0] ar, ai, br, bi,
                     input logic cj, input logic [7:0] tg,
                     input logic [15:0] er, ei, input logic eovf);
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_conj = cj; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk({name, "_early"}, out_valid, 1'b0);
    @(posedge clock); #1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_re"}, c_re, er);
    chk({name, "_im"}, c_im, ei);
    chk({name, "_tag"}, out_tag, tg);
    chk({name, "_ovf"}, out_ovf, eovf);
    @(posedge clock); #1;
    chk({name, "_once"}, out_valid, 1'b0);
  endtask

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [7:0]  tag;
    logic        ovf;
  } exp_t;

  // Stream n samples; pat_mode uses in_valid=1 with tags 0..n-1 and the
  // out_ready pattern 1,0,0,1,0,1,1,0, otherwise both sides are random.
  task automatic stream(input string name, input int n, input bit pat_mode);
    exp_t        q[$];
    exp_t        e;
    logic [32:0] m;
    logic [7:0]  pat = 8'b0110_1001;
    int          sent = 0, got = 0, cyc = 0;
    bit          stall = 1'b0;
    logic [15:0] h_re, h_im;
    logic [7:0]  h_tag;
    logic        h_ovf;
    while ((sent < n || got < n) && cyc < 3000) begin
      in_valid  = (sent < n) && (pat_mode || ($urandom_range(0, 3) != 0));
      a_re      = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      a_im      = 16'($urandom);
      b_re      = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b_im      = 16'($urandom);
      in_conj   = 1'($urandom_range(0, 1));
      in_tag    = pat_mode ? 8'(sent) : 8'($urandom);
      out_ready = pat_mode ? pat[cyc % 8] : ($urandom_range(0, 2) != 0);
      @(negedge clock);
      if (stall) begin
        chk({name, "_hold_valid"}, out_valid, 1'b1);
        chk({name, "_hold_re"}, c_re, h_re);
        chk({name, "_hold_im"}, c_im, h_im);
        chk({name, "_hold_tag"}, out_tag, h_tag);
        chk({name, "_hold_ovf"}, out_ovf, h_ovf);
      end
      chk({name, "_in_ready"}, in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk({name, "_expected_pending"}, q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk({name, "_re"}, c_re, e.re);
          chk({name, "_im"}, c_im, e.im);
          chk({name, "_tag"}, out_tag, e.tag);
          chk({name, "_ovf"}, out_ovf, e.ovf);
        end
        got++;
      end
      stall = out_valid && !out_ready;
      h_re = c_re; h_im = c_im; h_tag = out_tag; h_ovf = out_ovf;
      if (in_valid && in_ready) begin
        m = ref_cmul(a_re, a_im, b_re, b_im, in_conj);
        e.ovf = m[32]; e.re = m[31:16]; e.im = m[15:0]; e.tag = in_tag;
        q.push_back(e);
        sent++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    chk({name, "_count"}, got, n);
    chk({name, "_leftover"}, q.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  logic [15:0] r0, r1, r2, r3;
  logic        rc;
  logic [7:0]  rt;
  logic [32:0] m;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_conj = 1'b0; in_tag = '0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c_re", c_re, 16'h0000);
    chk("rst_c_im", c_im, 16'h0000);
    chk("rst_out_tag", out_tag, 8'h00);
    chk("rst_out_ovf", out_ovf, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;

    one("basic", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 8'h11, 16'h2000, 16'h0000, 1'b0);
    one("conj0", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 8'h22, 16'hE000, 16'h0000, 1'b0);
    one("conj1", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 8'h33, 16'h2000, 16'h0000, 1'b0);
    one("round_up", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 8'h44, 16'h0001, 16'h0000, 1'b0);
    one("round_neg", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 8'h55, 16'h0000, 16'h0000, 1'b0);
`ifdef CMUL_SATURATE_EN
    one("ovf", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 8'h66, 16'h7FFF, 16'h0000, 1'b1);
`else
    one("ovf", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 8'h66, 16'h8000, 16'h0000, 1'b0);
`endif

    for (int i = 0; i < 4; i++) begin
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rt = 8'($urandom);
      m  = ref_cmul(r0, r1, r2, r3, rc);
      one("rand1", r0, r1, r2, r3, rc, rt, m[31:16], m[15:0], m[32]);
    end

    stream("bp", 8, 1'b1);
    stream("rnd", 200, 1'b0);

    // Fill the pipe, stall the output, then reset with samples in flight.
    for (int i = 0; i < 4; i++) begin
      a_re = 16'($urandom); a_im = 16'($urandom); b_re = 16'($urandom); b_im = 16'($urandom);
      in_tag = 8'hA0 + 8'(i); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_pre_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_c_re", c_re, 16'h0000);
    chk("mid_rst_c_im", c_im, 16'h0000);
    chk("mid_rst_tag", out_tag, 8'h00);
    chk("mid_rst_ovf", out_ovf, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    a_re = 16'($urandom); a_im = 16'($urandom); b_re = 16'($urandom); b_im = 16'($urandom);
    in_conj = 1'($urandom_range(0, 1)); in_tag = 8'hB5; in_valid = 1'b1;
    m = ref_cmul(a_re, a_im, b_re, b_im, in_conj);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("post_rst_no_stale", out_valid, 1'b0);
    end
    @(posedge clock); #1;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_tag", out_tag, 8'hB5);
    chk("post_rst_re", c_re, m[31:16]);
    chk("post_rst_im", c_im, m[15:0]);
    chk("post_rst_ovf", out_ovf, m[32]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("post_rst_quiet", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmul_stream.md
Name: cmul_stream

Overview:
Parametrised streaming complex multiplier. It is the next generation of the FFT twiddle multiplier.
- Separate data and coefficient widths.
- Per-sample conjugate mode.
- Round-half-up rescaling.
- Valid/ready backpressure and a sideband tag.
- Sits between butterfly stages and the twiddle ROM; also usable for mixing and windowing.

Parameters:
DATA_WIDTH, 16, signed width of a_re/a_im (sample operand)
COEF_WIDTH, 16, signed width of b_re/b_im (coefficient operand)
OUT_WIDTH, 16, signed width of c_re/c_im
FRAC_SHIFT, 15, right shift applied to full-precision result (COEF_WIDTH-1 for Q1.x coefficients); must be >=1
TAG_WIDTH, 8, user sideband carried alongside each sample

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
in_conj  in  1  1: multiply by conj(b)
in_tag  in  TAG_WIDTH  sideband, returned unchanged with result
a_re, a_im  in  DATA_WIDTH  sample, signed
b_re, b_im  in  COEF_WIDTH  coefficient, signed
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
c_re, c_im  out  OUT_WIDTH  scaled result, signed
out_tag  out  TAG_WIDTH  tag of this result
out_ovf  out  1  result saturated (see Optional Feature)

Behaviour:
- Single clock. Reset is asynchronous, active-high.
- Reset clears all stage valid bits and output registers: out_valid=0, c_re=c_im=0, out_tag=0, out_ovf=0. Intermediate datapath registers are not reset.
- Pipeline stages, all advanced by one common enable adv = !out_valid | out_ready:
  - S1: register operands, conj, tag.
  - S2: four signed products, each P = DATA_WIDTH+COEF_WIDTH bits: pr1=ar*br, pr2=ai*bi, pr3=ar*bi, pr4=ai*br.
  - S3: sums, sign-extended to P+2 bits.
    - conj=0: re=pr1-pr2, im=pr4+pr3.
    - conj=1: re=pr1+pr2, im=pr4-pr3.
  - S4 (output register): each component becomes (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic shift), then is reduced to OUT_WIDTH.
- Handshake:
  - in_ready = adv; a transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Each stage's valid bit loads from the previous stage only when adv=1; otherwise all stages hold.
  - Bubbles (valid=0) propagate and are not compressed.
- Latency and throughput:
  - 4 cycles from input transfer to out_valid with out_ready held high.
  - Throughput 1 sample/cycle.
- Stall: while out_valid=1 and out_ready=0, every stage, in_ready, c_*, out_tag and out_ovf hold stable; no sample is lost or duplicated.
- Simultaneous output transfer and input transfer in the same cycle is legal (adv=1).
- Ordering: strictly in-order. Tag and conj travel with their sample.
- Reset mid-stream: all in-flight samples are discarded. The first sample accepted after reset release emerges after exactly 4 cycles.
- Operand -2^(W-1) is legal. Full precision is kept to S3; no intermediate overflow is possible.

Optional Feature:
Macro CMUL_SATURATE_EN.
- Defined: each shifted component outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps to the nearer limit. out_ovf=1 for that result if either component clamped.
- Undefined: components are truncated to their low OUT_WIDTH bits (two's-complement wrap) and out_ovf is tied to 0.

Test Plan:
- Basic: a=(0x4000,0), b=(0x4000,0), conj=0, tag=0x11, out_ready=1 -> 4 cycles later c=(0x2000,0x0000), out_tag=0x11, out_ovf=0.
- Conjugate: a=(0,0x4000), b=(0,0x4000).
  - conj=0 -> c=(0xE000,0x0000).
  - conj=1 -> c=(0x2000,0x0000).
- Rounding: a=(0x0001,0), b=(0x4000,0) -> c_re=0x0001 (0.5 LSB rounds up).
  - a=(0xFFFF,0), b=(0x4000,0) -> c_re=0x0000 (half-up toward +inf).
- Overflow: a=(0x8000,0), b=(0x8000,0).
  - With CMUL_SATURATE_EN -> c_re=0x7FFF, out_ovf=1.
  - Without -> c_re=0x8000, out_ovf=0.
- Backpressure: stream 8 samples with tags 0..7, in_valid=1; toggle out_ready with pattern 1,0,0,1,0,1,1,0 -> all 8 results emerge in order, none lost or duplicated; outputs stable while stalled; in_ready=0 exactly on stalled cycles.
- Reset mid-stream: assert reset for 1 cycle with 3 samples in flight -> out_valid=0 immediately (asynchronous) and no stale result appears afterwards. A new sample accepted in the first cycle after release -> out_valid exactly 4 cycles later.
